// File: rtl/sik_thread_scheduler_pkg.sv
// rtl/sik_thread_scheduler_pkg.sv - shared types and constants for the Sik thread scheduler
package sik_thread_scheduler_pkg;

    // Default machine word (PC) width and thread-id width
    localparam int WORD_W = 16;
    localparam int TID_W  = 1;

    // Default number of own-thread bubble slots after a stall request
    localparam int DEFAULT_STALL_SLOTS = 1;

    // Stall counter width; holds 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        TS_RUN   = 2'd0,
        TS_STALL = 2'd1,
        TS_HALT  = 2'd2
    } thread_state_e;

endpackage

// File: rtl/sik_thread_scheduler_ctx.sv
// rtl/sik_thread_scheduler_ctx.sv - per-thread run state, fetch PC and stall counter
module sik_thread_scheduler_ctx
    import sik_thread_scheduler_pkg::*;
#(
    parameter int PCW         = WORD_W,
    parameter int STALL_SLOTS = DEFAULT_STALL_SLOTS
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           own_i,
    input  logic           fire_i,
    input  logic           stall_i,
    input  logic           redir_i,
    input  logic [PCW-1:0] redir_pc_i,
    input  logic           halt_i,
    output logic           run_o,
    output logic           halted_o,
    output logic [PCW-1:0] pc_o
);

    thread_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PCW-1:0]   pc_q, pc_d;

    // Next-state: halt wins over everything; stall and redirect combine; a stalled thread burns own slots
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        if (state_q != TS_HALT) begin
            if (halt_i) begin
                state_d = TS_HALT;
            end else begin
                if (redir_i) begin
                    pc_d = redir_pc_i;
                end else if (fire_i) begin
                    pc_d = pc_q + 1'b1;
                end
                if (stall_i) begin
                    state_d = TS_STALL;
                    cnt_d   = CNT_W'(STALL_SLOTS);
                end else if (state_q == TS_STALL && own_i) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = TS_RUN;
                    end
                end
            end
        end
    end

    // Thread context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TS_RUN;
            cnt_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    assign run_o    = (state_q == TS_RUN);
    assign halted_o = (state_q == TS_HALT);
    assign pc_o     = pc_q;

endmodule

// File: rtl/sik_thread_scheduler.sv
// rtl/sik_thread_scheduler.sv - barrel-alternating issue controller for the 2-thread Sik pipeline
module sik_thread_scheduler
    import sik_thread_scheduler_pkg::*;
#(
    parameter int NTHREADS    = 2,
    parameter int PCW         = WORD_W,
    parameter int STALL_SLOTS = DEFAULT_STALL_SLOTS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_req,
    input  logic                stall_tid,
    input  logic                redir_req,
    input  logic                redir_tid,
    input  logic [PCW-1:0]      redir_pc,
    input  logic [NTHREADS-1:0] halt_req,
    output logic                issue_valid,
    output logic                issue_tid,
    output logic [PCW-1:0]      issue_pc,
    output logic [NTHREADS-1:0] halted,
    output logic                all_halted
);

    logic                slot_q;
    logic                issue_valid_q;
    logic                issue_tid_q;
    logic [PCW-1:0]      issue_pc_q;
    logic [NTHREADS-1:0] run_w;
    logic [NTHREADS-1:0] fire_w;
    logic [NTHREADS-1:0] halted_w;
    logic [PCW-1:0]      pc_w [NTHREADS];

    for (genvar g = 0; g < NTHREADS; g++) begin : g_ctx
        logic own;
        logic stall_hit;
        logic redir_hit;

        assign own       = (slot_q == 1'(g));
        assign stall_hit = stall_req && (stall_tid == 1'(g));
        assign redir_hit = redir_req && (redir_tid == 1'(g));
        // Any request aimed at the slot owner turns its slot into a bubble
        assign fire_w[g] = own && run_w[g] && !halt_req[g] && !stall_hit && !redir_hit;

        sik_thread_scheduler_ctx #(
            .PCW         (PCW),
            .STALL_SLOTS (STALL_SLOTS)
        ) u_ctx (
            .clk        (clk),
            .reset      (reset),
            .own_i      (own),
            .fire_i     (fire_w[g]),
            .stall_i    (stall_hit),
            .redir_i    (redir_hit),
            .redir_pc_i (redir_pc),
            .halt_i     (halt_req[g]),
            .run_o      (run_w[g]),
            .halted_o   (halted_w[g]),
            .pc_o       (pc_w[g])
        );
    end

    // Slot toggles every edge; registered issue outputs describe the slot owner at that edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q        <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_tid_q   <= 1'b0;
            issue_pc_q    <= '0;
        end else begin
            slot_q        <= ~slot_q;
            issue_valid_q <= fire_w[slot_q];
            issue_tid_q   <= slot_q;
            issue_pc_q    <= pc_w[slot_q];
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_tid   = issue_tid_q;
    assign issue_pc    = issue_pc_q;
    assign halted      = halted_w;
    assign all_halted  = &halted_w;

endmodule
